// File: rtl/sub_shift_stage.sv
// Iterative AES SubBytes + ShiftRows round stage.
// Registers one 128-bit state, substitutes COLS_PER_CYCLE columns per cycle in place, and on the
// last substitution cycle writes ShiftRows(SubBytes(state)) into a held output register.
// Byte layout: column c = bits [127-32c -: 32], row r of column c = [127-32c-8r -: 8].
// COLS_PER_CYCLE must be 1, 2 or 4.
module sub_shift_stage #(
    parameter int unsigned COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last
);

    localparam int unsigned NSUB  = 4 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W = (NSUB > 1) ? $clog2(NSUB) : 1;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

    state_e             fsm_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       state_q;
    logic               last_q;
    logic               out_valid_q;
    logic [127:0]       out_data_q;
    logic               out_last_q;

    logic [127:0]       sub_state;
    logic [127:0]       shifted;
    logic               accept;

    // in_ready is forced low while reset is held so nothing is accepted during reset.
    assign in_ready  = ~rst & ((fsm_q == StIdle) | ((fsm_q == StDone) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Substitute the column window selected by cnt_q; other columns pass through.
    always_comb begin : p_sub
        int unsigned col;
        sub_state = state_q;
        col       = 0;
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
            col = 32'(cnt_q) * COLS_PER_CYCLE + j;
            for (int unsigned r = 0; r < 4; r++) begin
                sub_state[127 - 32*col - 8*r -: 8] = sbox(state_q[127 - 32*col - 8*r -: 8]);
            end
        end
    end

    // ShiftRows: output byte (c, r) takes substituted byte ((c + r) mod 4, r).
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shifted[127 - 32*c - 8*r -: 8] = sub_state[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
    end

    // Control FSM, working state and held output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= StIdle;
            cnt_q       <= '0;
            state_q     <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (accept) begin
                        fsm_q   <= StSub;
                        cnt_q   <= '0;
                        state_q <= in_data;
                        last_q  <= in_last;
                    end
                end
                StSub: begin
                    if (cnt_q == CNT_W'(NSUB - 1)) begin
                        fsm_q       <= StDone;
                        out_data_q  <= shifted;
                        out_last_q  <= last_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= sub_state;
                    end
                end
                StDone: begin
                    // Output register holds until taken; a new block may load on the same edge.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            fsm_q   <= StSub;
                            cnt_q   <= '0;
                            state_q <= in_data;
                            last_q  <= in_last;
                        end else begin
                            fsm_q <= StIdle;
                        end
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Scoreboard bench for sub_shift_stage: one instance with 4 columns per cycle (index 0) and one
// with 1 column per cycle (index 1), sharing clock and reset.
module tb_sub_shift_stage;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    // FIPS-197 appendix B, rounds 1 and 2 (start of round -> after ShiftRows).
    localparam logic [127:0] V1 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] E1 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V2 = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] E2 = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] E0 = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [127:0] in_data  [2];
    logic [127:0] out_data [2];

    int n_vec  = 0;
    int n_fail = 0;

    logic [128:0] exp_q0[$];
    logic [128:0] exp_q1[$];

    always #5 clk = ~clk;

    sub_shift_stage #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0])
    );

    sub_shift_stage #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1])
    );

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        return SBOX_TAB[8*(255 - int'(x)) +: 8];
    endfunction

    // Reference round: bytes numbered 0..15 from the MSB, byte i = column i/4, row i%4.
    function automatic logic [127:0] ref_round(input logic [127:0] s);
        logic [7:0]   sb [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox_lookup(s[127 - 8*i -: 8]);
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = sb[(((i / 4) + (i % 4)) % 4) * 4 + (i % 4)];
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [128:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic pop_check(input int d);
        logic [128:0] e;
        bit           empty;
        e     = '0;
        empty = (d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            n_vec++;
            n_fail++;
            $display("FAIL dut%0d unexpected output: got %h, expected none", d, out_data[d]);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d out_data", d), out_data[d], e[127:0]);
            check($sformatf("dut%0d out_last", d), {127'b0, out_last[d]}, {127'b0, e[128]});
        end
    endtask

    // Monitor: every output handshake pops the oldest expected block.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && out_ready[d]) pop_check(d);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [127:0] data, input logic last,
                        input logic [127:0] exp);
        int n;
        n           = 0;
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_last[d]  = last;
        @(negedge clk);
        while (!in_ready[d] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready[d]) begin
            n_vec++;
            n_fail++;
            $display("FAIL dut%0d accept timeout: got in_ready 0, expected 1", d);
            @(posedge clk);
            #1;
        end else begin
            push(d, {last, exp});
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
    endtask

    // Edges from accept until out_valid; in_ready must stay low while substituting.
    task automatic measure(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!out_valid[d]) check($sformatf("dut%0d busy in_ready", d), {127'b0, in_ready[d]}, '0);
        end while (!out_valid[d] && lat < 50);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           n;
        logic [127:0] data;
        rst        = 1'b1;
        in_valid   = '0;
        in_last    = '0;
        out_ready  = 2'b11;
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d rst in_ready", d), {127'b0, in_ready[d]}, '0);
            check($sformatf("dut%0d rst out_valid", d), {127'b0, out_valid[d]}, '0);
            check($sformatf("dut%0d rst out_data", d), out_data[d], '0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("idle in_ready", {126'b0, in_ready}, 128'd3);
        @(posedge clk);
        #1;

        // FIPS vector, latency NSUB=1 and NSUB=4
        send(0, V1, 1'b0, E1);
        measure(0, lat);
        check("dut0 latency", 128'(lat), 128'd1);
        check("dut0 fips data", out_data[0], E1);
        @(posedge clk);
        #1;
        send(1, V1, 1'b0, E1);
        measure(1, lat);
        check("dut1 latency", 128'(lat), 128'd4);
        check("dut1 fips data", out_data[1], E1);
        @(posedge clk);
        #1;

        // All-zero state with last tag
        for (int d = 0; d < 2; d++) begin
            send(d, '0, 1'b1, E0);
            measure(d, lat);
            check($sformatf("dut%0d zero data", d), out_data[d], E0);
            check($sformatf("dut%0d zero last", d), {127'b0, out_last[d]}, 128'd1);
            @(posedge clk);
            #1;
        end

        // Backpressure on dut0
        out_ready[0] = 1'b0;
        send(0, V1, 1'b0, E1);
        measure(0, lat);
        in_valid[0] = 1'b1;
        in_data[0]  = V2;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp in_ready", {127'b0, in_ready[0]}, '0);
            check("bp out_valid", {127'b0, out_valid[0]}, 128'd1);
            check("bp out_data", out_data[0], E1);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp release in_ready", {127'b0, in_ready[0]}, 128'd1);
        push(0, {1'b1, E2});
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        measure(0, lat);
        check("bp second data", out_data[0], E2);
        @(posedge clk);
        #1;

        // Streams of 8 random blocks, back-to-back
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                data = {$urandom, $urandom, $urandom, $urandom};
                send(d, data, 1'(i), ref_round(data));
            end
        end
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stream drained", 128'(exp_q0.size() + exp_q1.size()), '0);

        // Reset mid-block: dut0 holds a result, dut1 is in its second substitution cycle
        out_ready[0] = 1'b0;
        send(0, V1, 1'b1, E1);
        measure(0, lat);
        send(1, V2, 1'b0, E2);
        @(posedge clk);
        #2;
        check("pre-rst dut0 out_data", out_data[0], E1);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d async out_valid", d), {127'b0, out_valid[d]}, '0);
            check($sformatf("dut%0d async out_data", d), out_data[d], '0);
            check($sformatf("dut%0d async out_last", d), {127'b0, out_last[d]}, '0);
        end
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 2'b11;
        repeat (8) @(posedge clk);
        #1;
        check("post-rst out_valid", {126'b0, out_valid}, '0);
        for (int d = 0; d < 2; d++) begin
            send(d, V2, 1'b1, E2);
            measure(d, lat);
            check($sformatf("dut%0d post-rst data", d), out_data[d], E2);
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("final drained", 128'(exp_q0.size() + exp_q1.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
